// File: rtl/rs_complex_pkg.sv
// ============================================================================
// rs_complex_pkg : shared payload layout and wakeup helper for rs_complex
// Revision: 1.0
// ============================================================================
`default_nettype none

package rs_complex_pkg;

  localparam int ROB_TAG_W   = 4;
  localparam int RS_ENTRY_W  = 114;
  localparam int DATA_W      = 32;
  localparam int NUM_ENTRIES = 2;

  localparam int MEMDATA_HI = 113;
  localparam int MEMDATA_LO = 82;
  localparam int ALUOP_HI   = 81;
  localparam int ALUOP_LO   = 76;
  localparam int MEMWRITE   = 75;
  localparam int MEMREAD    = 74;
  localparam int MEMTOREG   = 73;
  localparam int BRANCH     = 72;
  localparam int REGWRITE   = 71;
  localparam int SRC2_HI    = 70;
  localparam int SRC2_LO    = 39;
  localparam int SRC2_RDY   = 38;
  localparam int SRC1_HI    = 37;
  localparam int SRC1_LO    = 6;
  localparam int SRC1_RDY   = 5;
  localparam int WRADDR_HI  = 4;
  localparam int WRADDR_LO  = 0;

  // Returns {ready, value}; cdb0 takes precedence when both ports match.
  function automatic logic [DATA_W:0] cdb_wake(
    input logic                 rdy,
    input logic [DATA_W-1:0]    val,
    input logic [ROB_TAG_W-1:0] tag,
    input logic                 c0_valid,
    input logic [ROB_TAG_W-1:0] c0_tag,
    input logic [DATA_W-1:0]    c0_data,
    input logic                 c1_valid,
    input logic [ROB_TAG_W-1:0] c1_tag,
    input logic [DATA_W-1:0]    c1_data
  );
    logic [DATA_W:0] res;
    res = {rdy, val};
    if (!rdy) begin
      if (c0_valid && (c0_tag == tag))      res = {1'b1, c0_data};
      else if (c1_valid && (c1_tag == tag)) res = {1'b1, c1_data};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs_complex_entry.sv
// ============================================================================
// rs_complex_entry : one reservation-station slot with CDB wakeup and bypass
// Revision: 1.0
// ============================================================================
`default_nettype none

module rs_complex_entry
  import rs_complex_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [RS_ENTRY_W-1:0] wr_inst_i,
  input  logic [ROB_TAG_W-1:0]  wr_src1_tag_i,
  input  logic [ROB_TAG_W-1:0]  wr_src2_tag_i,
  input  logic [ROB_TAG_W-1:0]  wr_rob_num_i,
  input  logic                  issue_i,
  input  logic                  cdb0_valid_i,
  input  logic [ROB_TAG_W-1:0]  cdb0_tag_i,
  input  logic [DATA_W-1:0]     cdb0_data_i,
  input  logic                  cdb1_valid_i,
  input  logic [ROB_TAG_W-1:0]  cdb1_tag_i,
  input  logic [DATA_W-1:0]     cdb1_data_i,
  output logic                  valid_o,
  output logic [RS_ENTRY_W-1:0] entry_o,
  output logic [ROB_TAG_W-1:0]  rob_num_o
);

  logic                  valid_q,     valid_d;
  logic [RS_ENTRY_W-1:0] inst_q,      inst_d;
  logic [ROB_TAG_W-1:0]  src1_tag_q,  src1_tag_d;
  logic [ROB_TAG_W-1:0]  src2_tag_q,  src2_tag_d;
  logic [ROB_TAG_W-1:0]  rob_num_q,   rob_num_d;

  always_comb begin
    valid_d    = valid_q;
    inst_d     = inst_q;
    src1_tag_d = src1_tag_q;
    src2_tag_d = src2_tag_q;
    rob_num_d  = rob_num_q;

    if (valid_q) begin
      {inst_d[SRC1_RDY], inst_d[SRC1_HI:SRC1_LO]} = cdb_wake(
        inst_q[SRC1_RDY], inst_q[SRC1_HI:SRC1_LO], src1_tag_q,
        cdb0_valid_i, cdb0_tag_i, cdb0_data_i, cdb1_valid_i, cdb1_tag_i, cdb1_data_i);
      {inst_d[SRC2_RDY], inst_d[SRC2_HI:SRC2_LO]} = cdb_wake(
        inst_q[SRC2_RDY], inst_q[SRC2_HI:SRC2_LO], src2_tag_q,
        cdb0_valid_i, cdb0_tag_i, cdb0_data_i, cdb1_valid_i, cdb1_tag_i, cdb1_data_i);
    end

    if (issue_i) valid_d = 1'b0;

    // Writes only target a free slot, so they never collide with wakeup/issue.
    if (wr_en_i) begin
      inst_d     = wr_inst_i;
      src1_tag_d = wr_src1_tag_i;
      src2_tag_d = wr_src2_tag_i;
      rob_num_d  = wr_rob_num_i;
      valid_d    = 1'b1;
      {inst_d[SRC1_RDY], inst_d[SRC1_HI:SRC1_LO]} = cdb_wake(
        wr_inst_i[SRC1_RDY], wr_inst_i[SRC1_HI:SRC1_LO], wr_src1_tag_i,
        cdb0_valid_i, cdb0_tag_i, cdb0_data_i, cdb1_valid_i, cdb1_tag_i, cdb1_data_i);
      {inst_d[SRC2_RDY], inst_d[SRC2_HI:SRC2_LO]} = cdb_wake(
        wr_inst_i[SRC2_RDY], wr_inst_i[SRC2_HI:SRC2_LO], wr_src2_tag_i,
        cdb0_valid_i, cdb0_tag_i, cdb0_data_i, cdb1_valid_i, cdb1_tag_i, cdb1_data_i);
    end

    if (flush_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      inst_q     <= '0;
      src1_tag_q <= '0;
      src2_tag_q <= '0;
      rob_num_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      src1_tag_q <= src1_tag_d;
      src2_tag_q <= src2_tag_d;
      rob_num_q  <= rob_num_d;
    end
  end

  // An empty slot must never look ready to execute.
  always_comb begin
    entry_o           = inst_q;
    entry_o[SRC1_RDY] = inst_q[SRC1_RDY] & valid_q;
    entry_o[SRC2_RDY] = inst_q[SRC2_RDY] & valid_q;
  end

  assign valid_o   = valid_q;
  assign rob_num_o = rob_num_q;

endmodule

`default_nettype wire

// File: rtl/rs_complex.sv
// ============================================================================
// rs_complex : two-entry reservation station for the complex execute stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module rs_complex
  import rs_complex_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  disp_valid,
  input  logic [RS_ENTRY_W-1:0] disp_inst,
  input  logic [ROB_TAG_W-1:0]  disp_src1_tag,
  input  logic [ROB_TAG_W-1:0]  disp_src2_tag,
  input  logic [ROB_TAG_W-1:0]  disp_rob_num,
  output logic                  rs_full,
  input  logic                  cdb0_valid,
  input  logic [ROB_TAG_W-1:0]  cdb0_tag,
  input  logic [DATA_W-1:0]     cdb0_data,
  input  logic                  cdb1_valid,
  input  logic [ROB_TAG_W-1:0]  cdb1_tag,
  input  logic [DATA_W-1:0]     cdb1_data,
  output logic [RS_ENTRY_W-1:0] rs_complex_0,
  output logic [RS_ENTRY_W-1:0] rs_complex_1,
  output logic [ROB_TAG_W-1:0]  rs_complex_0_entry_num,
  output logic [ROB_TAG_W-1:0]  rs_complex_1_entry_num,
  output logic                  selector,
  input  logic                  complex_0_issue,
  input  logic                  complex_1_issue
);

  logic [NUM_ENTRIES-1:0] entry_valid;
  logic [NUM_ENTRIES-1:0] entry_wr;
  logic [NUM_ENTRIES-1:0] entry_issue;
  logic [RS_ENTRY_W-1:0]  entry_bus [NUM_ENTRIES];
  logic [ROB_TAG_W-1:0]   entry_rob [NUM_ENTRIES];
  logic                   disp_ok;
  logic                   sel_q, sel_d;

  assign rs_full     = &entry_valid;
  assign disp_ok     = disp_valid & ~rs_full & ~flush;
  assign entry_wr[0] = disp_ok & ~entry_valid[0];
  assign entry_wr[1] = disp_ok &  entry_valid[0] & ~entry_valid[1];
  assign entry_issue = {complex_1_issue, complex_0_issue};

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
    rs_complex_entry u_entry (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush_i       (flush),
      .wr_en_i       (entry_wr[i]),
      .wr_inst_i     (disp_inst),
      .wr_src1_tag_i (disp_src1_tag),
      .wr_src2_tag_i (disp_src2_tag),
      .wr_rob_num_i  (disp_rob_num),
      .issue_i       (entry_issue[i]),
      .cdb0_valid_i  (cdb0_valid),
      .cdb0_tag_i    (cdb0_tag),
      .cdb0_data_i   (cdb0_data),
      .cdb1_valid_i  (cdb1_valid),
      .cdb1_tag_i    (cdb1_tag),
      .cdb1_data_i   (cdb1_data),
      .valid_o       (entry_valid[i]),
      .entry_o       (entry_bus[i]),
      .rob_num_o     (entry_rob[i])
    );
  end

  // Selector tracks the most recently written slot.
  always_comb begin
    sel_d = sel_q;
    if (entry_wr[0])      sel_d = 1'b0;
    else if (entry_wr[1]) sel_d = 1'b1;
    if (flush)            sel_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sel_q <= 1'b0;
    else        sel_q <= sel_d;
  end

  assign selector               = sel_q;
  assign rs_complex_0           = entry_bus[0];
  assign rs_complex_1           = entry_bus[1];
  assign rs_complex_0_entry_num = entry_rob[0];
  assign rs_complex_1_entry_num = entry_rob[1];

endmodule

`default_nettype wire
